// File: rtl/dehaze_pkg.sv
// Shared pixel types and helpers for the dehaze pipeline stages.
package dehaze_pkg;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned CH_W  = 8;
  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [CH_W-1:0]  chan_t;

  typedef enum logic [0:0] {StIdle, StRun} dc_state_e;

  function automatic chan_t min3(input chan_t a, input chan_t b, input chan_t c);
    chan_t m;
    m = (a < b) ? a : b;
    m = (m < c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/pix_chan_min.sv
// Combinational min(R,G,B) of one packed RGB pixel.
module pix_chan_min
  import dehaze_pkg::*;
(
  input  logic [PIX_W-1:0] pix_i,
  output logic [CH_W-1:0]  min_o
);

  always_comb begin
    min_o = min3(pix_i[R_MSB -: CH_W], pix_i[G_MSB -: CH_W], pix_i[B_MSB -: CH_W]);
  end

endmodule

// File: rtl/dark_channel_3x3.sv
// 3x3 dark-channel window over three aligned row taps, with the aligned centre pixel.
module dark_channel_3x3
  import dehaze_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512,
  parameter int unsigned OUT_ROWS  = 510
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_top,
  input  logic [PIX_W-1:0] pix_mid,
  input  logic [PIX_W-1:0] pix_bot,
  input  logic             in_valid,
  output logic [CH_W-1:0]  dark_out,
  output logic [PIX_W-1:0] center_pix,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(OUT_ROWS - 1);

  logic [CH_W-1:0] cmin_top, cmin_mid, cmin_bot, colmin;

  pix_chan_min u_min_top (.pix_i(pix_top), .min_o(cmin_top));
  pix_chan_min u_min_mid (.pix_i(pix_mid), .min_o(cmin_mid));
  pix_chan_min u_min_bot (.pix_i(pix_bot), .min_o(cmin_bot));

  logic [CH_W-1:0]  c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;
  logic [PIX_W-1:0] p0_q, p1_q, p0_d, p1_d;
  logic             fire_q, fire_d, last_q, last_d;
  logic [ColW-1:0]  col_cnt_q, col_cnt_d;
  logic [RowW-1:0]  row_cnt_q, row_cnt_d;
  dc_state_e        state_q, state_d;
  logic [CH_W-1:0]  dark_q, dark_d;
  logic [PIX_W-1:0] center_q, center_d;
  logic             out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic             col_wrap, frame_end;

  always_comb begin
    colmin    = min3(cmin_top, cmin_mid, cmin_bot);
    col_wrap  = in_valid && (col_cnt_q == ColLast);
    frame_end = col_wrap && (row_cnt_q == RowLast);

    c0_d      = c0_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    state_d   = state_q;
    // Only a window-completing beat arms stage B; idle cycles leave it cleared.
    fire_d    = 1'b0;
    last_d    = frame_end;

    if (in_valid) begin
      c2_d      = c1_q;
      c1_d      = c0_q;
      c0_d      = colmin;
      p1_d      = p0_q;
      p0_d      = pix_mid;
      fire_d    = (col_cnt_q >= ColW'(2));
      col_cnt_d = col_wrap ? '0 : col_cnt_q + ColW'(1);
    end

    if (col_wrap) begin
      row_cnt_d = (row_cnt_q == RowLast) ? '0 : row_cnt_q + RowW'(1);
    end

    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    dark_d       = dark_q;
    center_d     = center_q;
    out_valid_d  = fire_q;
    frame_done_d = last_q;
    if (fire_q) begin
      dark_d   = min3(c0_q, c1_q, c2_q);
      center_d = p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_q         <= '0;
      c1_q         <= '0;
      c2_q         <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      fire_q       <= 1'b0;
      last_q       <= 1'b0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      state_q      <= StIdle;
      dark_q       <= '0;
      center_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      fire_q       <= fire_d;
      last_q       <= last_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      state_q      <= state_d;
      dark_q       <= dark_d;
      center_q     <= center_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dark_out   = dark_q;
  assign center_pix = center_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dark_channel_3x3.sv
// Scoreboard bench for dark_channel_3x3 with an 8x(2+2) frame geometry.
module tb_dark_channel_3x3;

  localparam int W = 8;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pix_top, pix_mid, pix_bot;
  logic        in_valid;
  logic [7:0]  dark_out;
  logic [23:0] center_pix;
  logic        out_valid, frame_done;

  dark_channel_3x3 #(.IMG_WIDTH(W), .OUT_ROWS(R)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .pix_top   (pix_top),
    .pix_mid   (pix_mid),
    .pix_bot   (pix_bot),
    .in_valid  (in_valid),
    .dark_out  (dark_out),
    .center_pix(center_pix),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dark;
    logic [23:0] center;
    logic        fd;
  } exp_t;

  typedef struct {
    logic [23:0] t, m, b;
    logic [7:0]  dark;
  } row_vec_t;

  exp_t     q[$];
  row_vec_t tab[4];
  int errors = 0, checks = 0;
  int n_valid = 0, n_fd = 0, n_dark10 = 0, n_ctr_dark = 0;
  logic [7:0]  cmins[W];
  logic [23:0] mids[W];
  int mcol = 0, mrow = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] bmin(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] pmin(input logic [23:0] p);
    return bmin(bmin(p[23:16], p[15:8]), p[7:0]);
  endfunction

  // Reference model: remembers column minima of the current row, emits expectation per window.
  task automatic beat(input logic [23:0] t, input logic [23:0] m, input logic [23:0] b,
                      input bit use_tab, input logic [7:0] tdark);
    exp_t e;
    cmins[mcol] = bmin(bmin(pmin(t), pmin(m)), pmin(b));
    mids[mcol]  = m;
    if (mcol >= 2) begin
      e.dark   = use_tab ? tdark : bmin(bmin(cmins[mcol-2], cmins[mcol-1]), cmins[mcol]);
      e.center = use_tab ? m : mids[mcol-1];
      e.fd     = (mcol == W - 1) && (mrow == R - 1);
      q.push_back(e);
    end
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == R - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
    pix_top  = t;
    pix_mid  = m;
    pix_bot  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dark_frame(input bit gappy);
    logic [23:0] m;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < W; c++) begin
        m = (r == 0 && c == 4) ? 24'hFF10FF : 24'hC0C0C0;
        beat(24'hC0C0C0, m, 24'hC0C0C0, 1'b0, 8'h00);
        if (gappy) idle(2);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_valid++;
      if (frame_done === 1'b1) n_fd++;
      if (dark_out == 8'h10) n_dark10++;
      if (center_pix == 24'hFF10FF) n_ctr_dark++;
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("dark_out", {24'd0, dark_out}, {24'd0, e.dark});
        check("center_pix", {8'd0, center_pix}, {8'd0, e.center});
        check("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
      end
    end else if (rst_n === 1'b1 && frame_done === 1'b1) begin
      check("stray_frame_done", 32'd1, 32'd0);
    end
  end

  int v0, f0, d0, k0;

  initial begin
    tab[0] = '{t: 24'h405080, m: 24'h405080, b: 24'h405080, dark: 8'h40};
    tab[1] = '{t: 24'h203040, m: 24'h808080, b: 24'h90A0B0, dark: 8'h20};
    tab[2] = '{t: 24'h000000, m: 24'h000000, b: 24'h000000, dark: 8'h00};
    tab[3] = '{t: 24'hFFFFFF, m: 24'hFFFFFF, b: 24'hFFFFFF, dark: 8'hFF};

    rst_n = 1'b1; in_valid = 1'b0;
    pix_top = '0; pix_mid = '0; pix_bot = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_dark", {24'd0, dark_out}, 32'd0);
    check("rst_center", {8'd0, center_pix}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table rows: uniform rows, with a 0x00 row followed by a 0xFF row across a row boundary.
    v0 = n_valid; f0 = n_fd;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < W; c++) begin
        beat(tab[i].t, tab[i].m, tab[i].b, 1'b1, tab[i].dark);
        if (i == 0 && c == 2) check("latency_col2", {31'd0, out_valid}, 32'd0);
        if (i == 0 && c == 3) check("latency_col3", {31'd0, out_valid}, 32'd1);
      end
    end
    idle(3);
    check("tab_results", n_valid - v0, 32'd24);
    check("tab_frames", n_fd - f0, 32'd2);
    check("tab_drained", q.size(), 32'd0);

    for (int g = 0; g < 2; g++) begin
      v0 = n_valid; f0 = n_fd; d0 = n_dark10; k0 = n_ctr_dark;
      dark_frame(g != 0);
      idle(3);
      check(g ? "gap_results" : "dark_results", n_valid - v0, 32'd12);
      check(g ? "gap_frames" : "dark_frames", n_fd - f0, 32'd1);
      check(g ? "gap_dark10" : "dark_dark10", n_dark10 - d0, 32'd3);
      check(g ? "gap_center" : "dark_center", n_ctr_dark - k0, 32'd1);
      check(g ? "gap_drained" : "dark_drained", q.size(), 32'd0);
    end

    // Reset lands while a result is on the outputs and another is armed.
    for (int i = 0; i < 12; i++) beat($urandom, $urandom, $urandom, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("midrst_dark", {24'd0, dark_out}, 32'd0);
    check("midrst_center", {8'd0, center_pix}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    q.delete();
    mcol = 0; mrow = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v0 = n_valid; f0 = n_fd;
    for (int i = 0; i < W * R; i++) beat($urandom, $urandom, $urandom, 1'b0, 8'h00);
    idle(3);
    check("postrst_results", n_valid - v0, 32'd12);
    check("postrst_frames", n_fd - f0, 32'd1);
    check("postrst_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dark_channel_3x3.md
Name: dark_channel_3x3

Overview:
- Consumes the three vertically aligned pixel taps produced by the double line buffer.
- Taps are: current row, row−1 and row−2, plus their shared valid.
- Forms a 3x3 sliding window and outputs the dark-channel value: min over all 9 pixels of min(R,G,B).
- Also outputs the window-centre RGB pixel, aligned with the dark value. Downstream, the atmospheric-light and transmission stages consume both.

Parameters:
- IMG_WIDTH, 512, pixels per row (≥3).
- OUT_ROWS, 510, window rows per frame, i.e. the number of output rows per frame (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_top  in  24  tap from the current row {R[23:16],G[15:8],B[7:0]}.
- pix_mid  in  24  tap from row−1 (the window centre row).
- pix_bot  in  24  tap from row−2.
- in_valid  in  1  all three taps valid this cycle.
- dark_out  out  8  3x3 dark-channel value.
- center_pix  out  24  RGB of the window centre pixel.
- out_valid  out  1  dark_out and center_pix valid; 1-cycle pulse per result.
- frame_done  out  1  pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset (rst=0, async): all outputs 0; col_cnt=0; row_cnt=0; FSM=IDLE; all shift registers 0.
- Input sampling: taps are sampled on a rising edge only when in_valid=1. There is no backpressure; every valid beat is accepted.
- Stage A, on each valid beat:
  - Per tap, compute cmin = min(R,G,B); then colmin = min(cmin_top, cmin_mid, cmin_bot).
  - Shift registers: c2<=c1, c1<=c0, c0<=colmin.
  - Centre-row registers: p1<=p0, p0<=pix_mid.
  - fire_q <= (col_cnt ≥ 2), else fire_q <= 0.
  - col_cnt increments and wraps IMG_WIDTH−1 → 0.
- Stage B, every edge:
  - If fire_q=1: dark_out <= min(c0,c1,c2); center_pix <= p1; out_valid <= 1.
  - Otherwise out_valid <= 0; dark_out and center_pix hold their last value.
- Latency: the result is visible 2 edges after the beat that completes the window (column k, k ≥ 2). center_pix is the pix_mid of column k−1.
- Output count: IMG_WIDTH−2 results per row. Columns 0 and 1 of every row produce no output.
- Row boundaries:
  - The window never straddles two rows. Stale c/p contents from the previous row are overwritten by columns 0–1 before fire_q can assert.
  - No explicit clear is needed.
- Gaps: in_valid=0 freezes col_cnt, row_cnt and the c/p registers. Results are identical to a gap-free stream; only their timing shifts.
- FSM:
  - IDLE → RUN on the first valid beat.
  - RUN: when col_cnt wraps, row_cnt increments.
  - The beat at col_cnt=IMG_WIDTH−1 and row_cnt=OUT_ROWS−1 sets a registered last flag, so frame_done=1 on the same edge as that result's out_valid. row_cnt → 0 and FSM → IDLE.
- Back-to-back frames: a valid beat in IDLE in the same cycle the frame completes is accepted normally.
- Reset mid-frame: counters and FSM return to IDLE immediately. Any in-flight out_valid is dropped, and the next valid beat is treated as column 0, row 0.
- Widths: all comparisons are unsigned 8-bit with no arithmetic growth. col_cnt is $clog2(IMG_WIDTH) bits and row_cnt is $clog2(OUT_ROWS) bits; minimum 1 bit each.

Decomposition:
- Shared package dehaze_pkg holds:
  - PIX_W=24, CH_W=8.
  - Channel slice constants R_MSB/G_MSB/B_MSB.
  - A min3 function for 8-bit values.
  - The pixel typedef reused by the upstream and downstream stages.
- Sub-module pix_chan_min: combinational min(R,G,B) of one 24-bit pixel. It is instantiated three times, once per tap.

Test Plan:
- Reset behaviour: apply rst=0 mid-stream at IMG_WIDTH=8, OUT_ROWS=2 → all outputs 0 within the same cycle. Next frame then yields exactly 12 out_valid pulses.
- Uniform image: pixel 0x405080 everywhere, IMG_WIDTH=8 → every dark_out=0x40. Exactly 6 results per row; first out_valid 2 edges after column-2 beat.
- Single dark pixel: pix_mid=0xFF10FF at column 4, all else 0xC0C0C0 → dark_out=0x10 for windows centred at columns 3, 4, 5; all other results 0xC0. center_pix=0xFF10FF only at the column-4 result.
- Gappy input: same stream as the single-dark-pixel case with in_valid toggled 1,0,0,1,… → identical dark_out/center_pix sequence; counts unchanged.
- Row boundary: row n ends with value 0x00 pixels, row n+1 starts with 0xFF → row n+1's first result equals min over its own columns 0–2 only (0xFF), never 0x00.
- Frame end: OUT_ROWS=2, IMG_WIDTH=8 → frame_done pulses once, with the 12th out_valid. A second frame starting the next cycle produces 12 more results and a second frame_done.
